sram_axi_bridge: RTL and testbench



---
 rtl/sram_axi_bridge_if.sv | 65 ++++++
 rtl/sram_axi_bridge.sv | 99 +++++++++
 tb/tb_sram_axi_bridge.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_bridge_if.sv
// sram_axi_bridge_if: SRAM-like core port bundle and AXI3 master bundle used by the bridge.
interface sram_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    modport master (output req, wr, size, addr, wstrb, wdata, input addr_ok, data_ok, rdata);
    modport slave (input req, wr, size, addr, wstrb, wdata, output addr_ok, data_ok, rdata);
endinterface

interface axi_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        input arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
    );
    modport slave (
        input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input wid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: merges the core's inst/data SRAM-like ports onto one AXI3 master, one outstanding access per port.
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input logic   clk,
    input logic   resetn,
    sram_if.slave inst,
    sram_if.slave data,
    axi_if.master axi
);
    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
    state_t      i_st, i_nxt, d_st, d_nxt;
    logic        rdy, d_wr, ar_valid, aw_valid, w_valid;
    logic [3:0]  ar_id, w_strb;
    logic [31:0] ar_addr, aw_addr, w_data;
    logic [1:0]  ar_size, aw_size;
    logic        ar_hs, wr_done, i_done, d_done, i_idle, d_idle, i_acc, d_rd_acc, d_wr_acc;
    logic        unused;
    assign unused = ^{inst.wr, inst.wstrb, inst.wdata, axi.rresp, axi.rlast, axi.bresp};
    // a port whose response lands this cycle counts as idle so it can take a new request at once
    always_comb begin
        ar_hs    = ar_valid && axi.arready;
        wr_done  = (!aw_valid || axi.awready) && (!w_valid || axi.wready);
        i_done   = i_st == RESP && axi.rvalid && axi.rid == INST_ID;
        d_done   = d_st == RESP && (d_wr ? axi.bvalid && axi.bid == DATA_ID : axi.rvalid && axi.rid == DATA_ID);
        i_idle   = i_st == IDLE || i_done;
        d_idle   = d_st == IDLE || d_done;
        d_rd_acc = rdy && d_idle && data.req && !data.wr && !ar_valid;
        d_wr_acc = rdy && d_idle && data.req && data.wr && !aw_valid && !w_valid;
        i_acc    = rdy && i_idle && inst.req && !ar_valid && !d_rd_acc;
        i_nxt    = i_acc ? ADDR : (i_st == ADDR && ar_hs && ar_id == INST_ID) ? RESP : i_done ? IDLE : i_st;
        d_nxt    = (d_rd_acc || d_wr_acc) ? ADDR :
                   (d_st == ADDR && (d_wr ? wr_done : ar_hs && ar_id == DATA_ID)) ? RESP : d_done ? IDLE : d_st;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_st     <= IDLE;
            d_st     <= IDLE;
            rdy      <= 1'b0;
            d_wr     <= 1'b0;
            ar_valid <= 1'b0;
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
        end else begin
            i_st     <= i_nxt;
            d_st     <= d_nxt;
            rdy      <= 1'b1;
            d_wr     <= (d_rd_acc || d_wr_acc) ? data.wr : d_wr;
            ar_valid <= i_acc || d_rd_acc || (ar_valid && !axi.arready);
            aw_valid <= d_wr_acc || (aw_valid && !axi.awready);
            w_valid  <= d_wr_acc || (w_valid && !axi.wready);
        end
    end
    always_ff @(posedge clk) begin
        if (i_acc || d_rd_acc) begin
            ar_id   <= d_rd_acc ? DATA_ID : INST_ID;
            ar_addr <= d_rd_acc ? data.addr : inst.addr;
            ar_size <= d_rd_acc ? data.size : inst.size;
        end
        if (d_wr_acc) begin
            aw_addr <= data.addr;
            aw_size <= data.size;
            w_data  <= data.wdata;
            w_strb  <= data.wstrb;
        end
    end
    assign inst.addr_ok = i_acc;
    assign inst.data_ok = i_done;
    assign inst.rdata   = axi.rdata;
    assign data.addr_ok = d_rd_acc || d_wr_acc;
    assign data.data_ok = d_done;
    assign data.rdata   = axi.rdata;
    assign axi.arid     = ar_id;
    assign axi.araddr   = ar_addr;
    assign axi.arlen    = 4'd0;
    assign axi.arsize   = {1'b0, ar_size};
    assign axi.arburst  = 2'b01;
    assign axi.arlock   = 2'd0;
    assign axi.arcache  = 4'd0;
    assign axi.arprot   = 3'd0;
    assign axi.arvalid  = ar_valid;
    assign axi.rready   = rdy;
    assign axi.awid     = DATA_ID;
    assign axi.awaddr   = aw_addr;
    assign axi.awlen    = 4'd0;
    assign axi.awsize   = {1'b0, aw_size};
    assign axi.awburst  = 2'b01;
    assign axi.awlock   = 2'd0;
    assign axi.awcache  = 4'd0;
    assign axi.awprot   = 3'd0;
    assign axi.awvalid  = aw_valid;
    assign axi.wid      = DATA_ID;
    assign axi.wdata    = w_data;
    assign axi.wstrb    = w_strb;
    assign axi.wlast    = 1'b1;
    assign axi.wvalid   = w_valid;
    assign axi.bready   = rdy;
endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: directed stimulus with queued expectations checked by a decoupled monitor.
module tb_sram_axi_bridge;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;
    sram_if inst_if();
    sram_if data_if();
    axi_if  axi();
    sram_axi_bridge dut (.clk(clk), .resetn(resetn), .inst(inst_if), .data(data_if), .axi(axi));
    int pass_n = 0;
    int total_n = 0;
    logic [38:0] ar_q[$];
    logic [38:0] aw_q[$];
    logic [40:0] w_q[$];
    logic [31:0] iq[$];
    logic [32:0] dq[$];
    logic [32:0] de;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act !== exp) $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        else pass_n++;
    endfunction

    always @(negedge clk) begin
        if (axi.arvalid && axi.arready) begin
            if (ar_q.size() > 0) chk("ar_payload", {25'd0, axi.arid, axi.araddr, axi.arsize}, {25'd0, ar_q.pop_front()});
            else chk("ar_unexpected", {63'd0, axi.arvalid}, 64'd0);
        end
        if (axi.awvalid && axi.awready) begin
            if (aw_q.size() > 0) chk("aw_payload", {25'd0, axi.awid, axi.awaddr, axi.awsize}, {25'd0, aw_q.pop_front()});
            else chk("aw_unexpected", {63'd0, axi.awvalid}, 64'd0);
        end
        if (axi.wvalid && axi.wready) begin
            if (w_q.size() > 0) chk("w_payload", {23'd0, axi.wid, axi.wdata, axi.wstrb, axi.wlast}, {23'd0, w_q.pop_front()});
            else chk("w_unexpected", {63'd0, axi.wvalid}, 64'd0);
        end
        if (inst_if.data_ok) begin
            if (iq.size() > 0) chk("inst_rdata", {32'd0, inst_if.rdata}, {32'd0, iq.pop_front()});
            else chk("inst_unexpected_data_ok", {63'd0, inst_if.data_ok}, 64'd0);
        end
        if (data_if.data_ok) begin
            if (dq.size() > 0) begin
                de = dq.pop_front();
                if (de[32]) chk("data_wr_ack", {59'd0, axi.bvalid, axi.bid}, {59'd0, 1'b1, 4'd1});
                else chk("data_rdata", {32'd0, data_if.rdata}, {32'd0, de[31:0]});
            end else chk("data_unexpected_data_ok", {63'd0, data_if.data_ok}, 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic dual(input bit inst_first, input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] ir, input logic [31:0] dr);
        step();
        inst_if.req = 1; inst_if.addr = ia; inst_if.size = 2'd2;
        data_if.req = 1; data_if.wr = 0; data_if.addr = da; data_if.size = 2'd1;
        ar_q.push_back({4'd1, da, 3'd1});
        ar_q.push_back({4'd0, ia, 3'd2});
        iq.push_back(ir);
        dq.push_back({1'b0, dr});
        smp();
        chk("dual_data_addr_ok", {63'd0, data_if.addr_ok}, 64'd1);
        chk("dual_inst_addr_ok", {63'd0, inst_if.addr_ok}, 64'd0);
        step(); data_if.req = 0; axi.arready = 1;
        smp(); chk("dual_inst_blocked", {63'd0, inst_if.addr_ok}, 64'd0);
        step(); axi.arready = 0;
        smp(); chk("dual_inst_retry", {63'd0, inst_if.addr_ok}, 64'd1);
        step(); inst_if.req = 0; axi.arready = 1;
        step(); axi.arready = 0;
        step(); axi.rvalid = 1; axi.rid = inst_first ? 4'd0 : 4'd1; axi.rdata = inst_first ? ir : dr;
        step(); axi.rid = inst_first ? 4'd1 : 4'd0; axi.rdata = inst_first ? dr : ir;
        step(); axi.rvalid = 0;
    endtask

    initial begin
        inst_if.req = 1; inst_if.wr = 0; inst_if.size = 2'd2; inst_if.addr = 0; inst_if.wstrb = 0; inst_if.wdata = 0;
        data_if.req = 0; data_if.wr = 0; data_if.size = 0; data_if.addr = 0; data_if.wstrb = 0; data_if.wdata = 0;
        axi.arready = 0; axi.awready = 0; axi.wready = 0;
        axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 1; axi.rvalid = 0;
        axi.bid = 0; axi.bresp = 0; axi.bvalid = 0;
        repeat (3) step();
        smp();
        chk("rst_valids", {61'd0, axi.arvalid, axi.awvalid, axi.wvalid}, 64'd0);
        chk("rst_addr_ok", {63'd0, inst_if.addr_ok}, 64'd0);
        step(); resetn = 1; inst_if.req = 0;
        step();
        smp();
        chk("rready_bready", {62'd0, axi.rready, axi.bready}, 64'd3);
        chk("ar_consts", {49'd0, axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot}, {49'd0, 4'd0, 2'b01, 2'd0, 4'd0, 3'd0});
        chk("aw_consts", {48'd0, axi.awlen, axi.awburst, axi.awlock, axi.awcache, axi.awprot, axi.wlast},
            {48'd0, 4'd0, 2'b01, 2'd0, 4'd0, 3'd0, 1'b1});
        // single inst read
        step(); inst_if.req = 1; inst_if.addr = 32'hBFC00000; inst_if.size = 2'd2;
        ar_q.push_back({4'd0, 32'hBFC00000, 3'd2});
        iq.push_back(32'h3C080001);
        smp(); chk("t1_addr_ok", {63'd0, inst_if.addr_ok}, 64'd1);
        step(); inst_if.req = 0; axi.arready = 1;
        smp(); chk("t1_arvalid", {63'd0, axi.arvalid}, 64'd1);
        step(); axi.arready = 0;
        smp(); chk("t1_arvalid_drop", {63'd0, axi.arvalid}, 64'd0);
        step();
        step(); axi.rvalid = 1; axi.rid = 4'd0; axi.rdata = 32'h3C080001;
        smp(); chk("t1_data_ok", {63'd0, inst_if.data_ok}, 64'd1);
        step(); axi.rvalid = 0;
        smp(); chk("t1_data_ok_drop", {63'd0, inst_if.data_ok}, 64'd0);
        // same-cycle reads, both return orders
        dual(1'b0, 32'h00001000, 32'h00002000, 32'h11111111, 32'hD0D0D0D0);
        dual(1'b1, 32'h00001100, 32'h00002200, 32'h22222222, 32'hE0E0E0E0);
        // write with delayed awready
        step(); data_if.req = 1; data_if.wr = 1; data_if.addr = 32'h80001000; data_if.size = 2'd2;
        data_if.wstrb = 4'b0011; data_if.wdata = 32'h1234ABCD;
        aw_q.push_back({4'd1, 32'h80001000, 3'd2});
        w_q.push_back({4'd1, 32'h1234ABCD, 4'b0011, 1'b1});
        dq.push_back({1'b1, 32'd0});
        smp(); chk("wr_addr_ok", {63'd0, data_if.addr_ok}, 64'd1);
        step(); data_if.wr = 0; data_if.addr = 32'h00003000; axi.wready = 1;
        smp(); chk("wr_c1_valids", {62'd0, axi.awvalid, axi.wvalid}, 64'd3);
        chk("wr_busy_addr_ok", {63'd0, data_if.addr_ok}, 64'd0);
        step(); axi.wready = 0;
        smp(); chk("wr_c2_valids", {62'd0, axi.awvalid, axi.wvalid}, 64'd2);
        step(); axi.awready = 1;
        smp(); chk("wr_c3_valids", {62'd0, axi.awvalid, axi.wvalid}, 64'd2);
        chk("wr_busy_addr_ok2", {63'd0, data_if.addr_ok}, 64'd0);
        step(); axi.awready = 0; data_if.req = 0;
        smp(); chk("wr_c4_valids", {62'd0, axi.awvalid, axi.wvalid}, 64'd0);
        chk("wr_no_early_ok", {63'd0, data_if.data_ok}, 64'd0);
        step(); axi.bvalid = 1; axi.bid = 4'd1;
        smp(); chk("wr_data_ok", {63'd0, data_if.data_ok}, 64'd1);
        step(); axi.bvalid = 0;
        // arready stall, then a stray ID
        step(); data_if.req = 1; data_if.wr = 0; data_if.addr = 32'hA0000004; data_if.size = 2'd0;
        ar_q.push_back({4'd1, 32'hA0000004, 3'd0});
        dq.push_back({1'b0, 32'h55AA55AA});
        step(); data_if.req = 0;
        for (int i = 0; i < 5; i++) begin
            smp(); chk("stall_ar", {24'd0, axi.arvalid, axi.arid, axi.araddr, axi.arsize}, {24'd0, 1'b1, 4'd1, 32'hA0000004, 3'd0});
            step();
        end
        axi.arready = 1;
        step(); axi.arready = 0;
        step(); axi.rvalid = 1; axi.rid = 4'd5; axi.rdata = 32'hDEADBEEF;
        smp(); chk("stray_id", {63'd0, data_if.data_ok}, 64'd0);
        step(); axi.rid = 4'd1; axi.rdata = 32'h55AA55AA;
        step(); axi.rvalid = 0;
        // reset while inst in RESP and a write is waiting
        step(); inst_if.req = 1; inst_if.addr = 32'h00003000; inst_if.size = 2'd2;
        data_if.req = 1; data_if.wr = 1; data_if.addr = 32'h80002000; data_if.wdata = 32'h0BADF00D; data_if.wstrb = 4'hF;
        ar_q.push_back({4'd0, 32'h00003000, 3'd2});
        step(); inst_if.req = 0; data_if.req = 0; data_if.wr = 0; axi.arready = 1;
        step(); axi.arready = 0;
        smp(); chk("pre_rst_wr_valids", {62'd0, axi.awvalid, axi.wvalid}, 64'd3);
        step(); resetn = 0;
        smp(); chk("mid_rst_valids", {61'd0, axi.arvalid, axi.awvalid, axi.wvalid}, 64'd0);
        step(); resetn = 1;
        step(); axi.rvalid = 1; axi.rid = 4'd0; axi.rdata = 32'h12345678; axi.bvalid = 1; axi.bid = 4'd1;
        smp(); chk("post_rst_no_ok", {62'd0, inst_if.data_ok, data_if.data_ok}, 64'd0);
        step(); axi.rvalid = 0; axi.bvalid = 0;
        // back-to-back inst reads
        step(); inst_if.req = 1; inst_if.addr = 32'h00004000;
        ar_q.push_back({4'd0, 32'h00004000, 3'd2});
        ar_q.push_back({4'd0, 32'h00004004, 3'd2});
        iq.push_back(32'hAAAA0001);
        iq.push_back(32'hAAAA0002);
        smp(); chk("b2b_first_addr_ok", {63'd0, inst_if.addr_ok}, 64'd1);
        step(); inst_if.addr = 32'h00004004; axi.arready = 1;
        smp(); chk("b2b_wait_addr_ok", {63'd0, inst_if.addr_ok}, 64'd0);
        step(); axi.arready = 0;
        smp(); chk("b2b_resp_addr_ok", {63'd0, inst_if.addr_ok}, 64'd0);
        step(); axi.rvalid = 1; axi.rid = 4'd0; axi.rdata = 32'hAAAA0001;
        smp(); chk("b2b_ok_and_accept", {62'd0, inst_if.data_ok, inst_if.addr_ok}, 64'd3);
        step(); axi.rvalid = 0; inst_if.req = 0; axi.arready = 1;
        step(); axi.arready = 0;
        step(); axi.rvalid = 1; axi.rid = 4'd0; axi.rdata = 32'hAAAA0002;
        step(); axi.rvalid = 0;
        step(); step();
        chk("ar_q_drained", {32'd0, ar_q.size()}, 64'd0);
        chk("aw_q_drained", {32'd0, aw_q.size()}, 64'd0);
        chk("w_q_drained", {32'd0, w_q.size()}, 64'd0);
        chk("inst_q_drained", {32'd0, iq.size()}, 64'd0);
        chk("data_q_drained", {32'd0, dq.size()}, 64'd0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
